tlb_assoc: RTL and testbench

- Parametrised, fully associative TLB; successor to the fixed 8-entry TLB in the pipeline.
- Translates the fetch port (port 0) and the memory port (port 1) combinationally, with a third lookup port for TLB-read instructions.
- Adds the following over the previous block:
  - per-entry permission and global bits
  - in-place update of an existing mapping
  - invalid-first replacement
  - a multi-cycle flush-by-PID sweep engine alongside the single-cycle flush-all.

---
 rtl/tlb_assoc.sv | 273 +++++++++++++++++++++++++++
 tb/tb_tlb_assoc.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_assoc.sv
// tlb_assoc: parametrised, fully associative translation lookaside buffer.
//
// Three combinational lookup paths read the registered entry array:
//   port 0 (fetch), port 1 (memory, with permission and upstream-exception
//   handling) and an exact-key read port used by TLB read/write/invalidate
//   instructions. Writes overwrite an existing exact-key mapping in place.
//   If there is no such mapping, they fill the lowest invalid entry. If the
//   array is full, they evict the entry at a round-robin pointer.
//   flush_all clears the whole array in one cycle. flush_pid_req starts a
//   sweep that visits one entry per enabled cycle. The sweep invalidates the
//   non-global entries that belong to the latched PID.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clk_en           qualifies every state update
//   kmode, pid       current privilege (1 = kernel) and process ID
//   addr0            fetch virtual address
//   addr1            memory virtual address
//   acc1_wr          port-1 access is a store
//   bubble1          port-1 slot is a bubble
//   exc_in           upstream exception for the port-1 instruction
//   read_key         {pid, vpn} key for read/write instructions
//   we               write request
//   wdata_ppn        PPN for the write
//   wdata_perm       {U,X,W,R} for the write
//   wdata_g          global bit for the write
//   flush_all        invalidate the whole array
//   flush_pid_req    request a PID sweep
//   flush_pid        PID to sweep
//   busy             a sweep is in progress
//   exc_out0/1       exception codes for ports 0 and 1
//   addr0/1_out      physical addresses (or a vector address on port 1)
//   read_hit         read_key matches a valid entry
//   read_ppn         PPN of the matching entry (0 on a miss)
module tlb_assoc #(
    parameter int          ENTRIES      = 16,
    parameter int          PID_W        = 12,
    parameter int          VPN_W        = 20,
    parameter int          PPN_W        = 6,
    parameter int          OFF_W        = 12,
    parameter logic [31:0] BYPASS_LIMIT = 32'h30000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   kmode,
    input  logic [PID_W-1:0]       pid,
    input  logic [31:0]            addr0,
    input  logic [31:0]            addr1,
    input  logic                   acc1_wr,
    input  logic                   bubble1,
    input  logic [7:0]             exc_in,
    input  logic [PID_W+VPN_W-1:0] read_key,
    input  logic                   we,
    input  logic [PPN_W-1:0]       wdata_ppn,
    input  logic [3:0]             wdata_perm,
    input  logic                   wdata_g,
    input  logic                   flush_all,
    input  logic                   flush_pid_req,
    input  logic [PID_W-1:0]       flush_pid,
    output logic                   busy,
    output logic [7:0]             exc_out0,
    output logic [7:0]             exc_out1,
    output logic [PPN_W+OFF_W-1:0] addr0_out,
    output logic [PPN_W+OFF_W-1:0] addr1_out,
    output logic                   read_hit,
    output logic [PPN_W-1:0]       read_ppn
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PA_W  = PPN_W + OFF_W;

    typedef enum logic {IDLE, SWEEP} sweep_state_t;

    // Entry storage; perm is {U,X,W,R}
    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_g;
    logic [PID_W-1:0]   ent_pid  [ENTRIES];
    logic [VPN_W-1:0]   ent_vpn  [ENTRIES];
    logic [PPN_W-1:0]   ent_ppn  [ENTRIES];
    logic [3:0]         ent_perm [ENTRIES];

    logic [IDX_W-1:0]   rr_ptr;

    sweep_state_t       state, next_state;
    logic [IDX_W-1:0]   sweep_idx;
    logic [PID_W-1:0]   sweep_pid;
    logic               sweep_start;

    logic               hit0, hit1;
    logic [PPN_W-1:0]   ppn0, ppn1;
    logic [3:0]         perm0, perm1;
    logic [IDX_W-1:0]   key_idx;
    logic               inv_found;
    logic [IDX_W-1:0]   inv_idx;
    logic               bypass0, bypass1;
    logic               wr_fire;
    logic [IDX_W-1:0]   wr_idx;

    logic [PID_W-1:0]   key_pid;
    logic [VPN_W-1:0]   key_vpn;

    assign key_pid = read_key[PID_W+VPN_W-1:VPN_W];
    assign key_vpn = read_key[VPN_W-1:0];
    assign busy    = (state == SWEEP);

    // Associative search of all three ports. At most one entry matches any key,
    // so OR-ing the payloads of the matching entries gives the hit entry's payload.
    // The lowest invalid index is also located for the write path.
    always_comb begin
        hit0      = 1'b0;
        hit1      = 1'b0;
        ppn0      = '0;
        ppn1      = '0;
        perm0     = '0;
        perm1     = '0;
        read_hit  = 1'b0;
        read_ppn  = '0;
        key_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_valid[i] && ent_vpn[i] == addr0[31:OFF_W] &&
                (ent_g[i] || ent_pid[i] == pid)) begin
                hit0  = 1'b1;
                ppn0  = ppn0 | ent_ppn[i];
                perm0 = perm0 | ent_perm[i];
            end
            if (ent_valid[i] && ent_vpn[i] == addr1[31:OFF_W] &&
                (ent_g[i] || ent_pid[i] == pid)) begin
                hit1  = 1'b1;
                ppn1  = ppn1 | ent_ppn[i];
                perm1 = perm1 | ent_perm[i];
            end
            if (ent_valid[i] && ent_pid[i] == key_pid && ent_vpn[i] == key_vpn) begin
                read_hit = 1'b1;
                read_ppn = read_ppn | ent_ppn[i];
                key_idx  = IDX_W'(i);
            end
            if (!ent_valid[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
    end

    assign bypass0 = kmode && (addr0 < BYPASS_LIMIT);
    assign bypass1 = kmode && (addr1 < BYPASS_LIMIT);

    // Fetch port: miss, then execute permission, then user permission
    always_comb begin
        exc_out0  = 8'h00;
        addr0_out = '0;
        if (bypass0) begin
            addr0_out = addr0[PA_W-1:0];
        end else if (!hit0) begin
            exc_out0 = kmode ? 8'h83 : 8'h82;
        end else if (!perm0[2]) begin
            exc_out0 = 8'h86;
        end else if (!kmode && !perm0[3]) begin
            exc_out0 = 8'h84;
        end else begin
            addr0_out = {ppn0, addr0[OFF_W-1:0]};
        end
    end

    // Memory port: an upstream exception always wins, and a bubble masks
    // translation faults. Any exception turns the address into a vector.
    always_comb begin
        exc_out1  = 8'h00;
        addr1_out = '0;
        if (exc_in != 8'h00) begin
            exc_out1 = exc_in;
        end else if (bubble1 || bypass1) begin
            exc_out1 = 8'h00;
        end else if (!hit1) begin
            exc_out1 = kmode ? 8'h83 : 8'h82;
        end else if (acc1_wr ? !perm1[1] : !perm1[0]) begin
            exc_out1 = 8'h85;
        end else if (!kmode && !perm1[3]) begin
            exc_out1 = 8'h84;
        end
        if (exc_out1 != 8'h00) begin
            addr1_out = {{(PA_W-10){1'b0}}, exc_out1, 2'b00};
        end else if (bypass1) begin
            addr1_out = addr1[PA_W-1:0];
        end else if (hit1) begin
            addr1_out = {ppn1, addr1[OFF_W-1:0]};
        end
    end

    // Write slot: in-place update, else lowest invalid entry, else round robin
    assign wr_fire = clk_en && we && !busy && !flush_all;
    assign wr_idx  = read_hit ? key_idx : (inv_found ? inv_idx : rr_ptr);

    // Entry array and replacement pointer. A write and a sweep invalidation
    // can never occur in the same cycle, because writes are blocked while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_g     <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_pid[i]  <= '0;
                ent_vpn[i]  <= '0;
                ent_ppn[i]  <= '0;
                ent_perm[i] <= '0;
            end
        end else if (clk_en) begin
            if (flush_all) begin
                ent_valid <= '0;
                rr_ptr    <= '0;
            end else begin
                if (wr_fire) begin
                    ent_valid[wr_idx] <= 1'b1;
                    ent_g[wr_idx]     <= wdata_g;
                    ent_pid[wr_idx]   <= key_pid;
                    ent_vpn[wr_idx]   <= key_vpn;
                    ent_ppn[wr_idx]   <= wdata_ppn;
                    ent_perm[wr_idx]  <= wdata_perm;
                    if (!read_hit && !inv_found) begin
                        rr_ptr <= rr_ptr + IDX_W'(1);
                    end
                end
                if (state == SWEEP && !ent_g[sweep_idx] &&
                    ent_pid[sweep_idx] == sweep_pid) begin
                    ent_valid[sweep_idx] <= 1'b0;
                end
            end
        end
    end

    // Sweep FSM next state. flush_all aborts any sweep and blocks a new one.
    always_comb begin
        next_state  = state;
        sweep_start = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pid_req && !flush_all) begin
                    next_state  = SWEEP;
                    sweep_start = 1'b1;
                end
            end
            SWEEP: begin
                if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (flush_all) begin
            next_state = IDLE;
        end
    end

    // Sweep state, index and latched target PID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sweep_idx <= '0;
            sweep_pid <= '0;
        end else if (clk_en) begin
            state <= next_state;
            if (sweep_start) begin
                sweep_idx <= '0;
                sweep_pid <= flush_pid;
            end else if (state == SWEEP) begin
                sweep_idx <= sweep_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: self-checking bench for tlb_assoc (default parameters).
// A table of lookup vectors exercises the translation and exception paths.
// Hand-written sequences cover replacement, the PID sweep, the sweep abort,
// clock-enable gating and reset.
module tb_tlb_assoc;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        kmode;
    logic [11:0] pid;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        acc1_wr;
    logic        bubble1;
    logic [7:0]  exc_in;
    logic [31:0] read_key;
    logic        we;
    logic [5:0]  wdata_ppn;
    logic [3:0]  wdata_perm;
    logic        wdata_g;
    logic        flush_all;
    logic        flush_pid_req;
    logic [11:0] flush_pid;
    logic        busy;
    logic [7:0]  exc_out0;
    logic [7:0]  exc_out1;
    logic [17:0] addr0_out;
    logic [17:0] addr1_out;
    logic        read_hit;
    logic [5:0]  read_ppn;

    int checks;
    int failures;

    typedef struct {
        logic        kmode;
        logic [11:0] pid;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        wr;
        logic        bub;
        logic [7:0]  ein;
        logic [7:0]  e0;
        logic [17:0] o0;
        logic [7:0]  e1;
        logic [17:0] o1;
        logic        chk_o1;
    } vec_t;

    vec_t vq[$];

    tlb_assoc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .kmode         (kmode),
        .pid           (pid),
        .addr0         (addr0),
        .addr1         (addr1),
        .acc1_wr       (acc1_wr),
        .bubble1       (bubble1),
        .exc_in        (exc_in),
        .read_key      (read_key),
        .we            (we),
        .wdata_ppn     (wdata_ppn),
        .wdata_perm    (wdata_perm),
        .wdata_g       (wdata_g),
        .flush_all     (flush_all),
        .flush_pid_req (flush_pid_req),
        .flush_pid     (flush_pid),
        .busy          (busy),
        .exc_out0      (exc_out0),
        .exc_out1      (exc_out1),
        .addr0_out     (addr0_out),
        .addr1_out     (addr1_out),
        .read_hit      (read_hit),
        .read_ppn      (read_ppn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic k, input logic [11:0] p, input logic [31:0] a0,
                           input logic [31:0] a1, input logic wr, input logic bub,
                           input logic [7:0] ein, input logic [7:0] e0, input logic [17:0] o0,
                           input logic [7:0] e1, input logic [17:0] o1, input logic chk_o1);
        vec_t v;
        v.kmode = k;  v.pid = p;  v.a0 = a0;  v.a1 = a1;
        v.wr = wr;    v.bub = bub; v.ein = ein;
        v.e0 = e0;    v.o0 = o0;  v.e1 = e1;  v.o1 = o1;  v.chk_o1 = chk_o1;
        vq.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        kmode   = v.kmode;
        pid     = v.pid;
        addr0   = v.a0;
        addr1   = v.a1;
        acc1_wr = v.wr;
        bubble1 = v.bub;
        exc_in  = v.ein;
        #1;
    endtask

    task automatic checkOutput(input int n, input vec_t v);
        check($sformatf("vec%0d exc_out0", n), {24'd0, exc_out0}, {24'd0, v.e0});
        check($sformatf("vec%0d addr0_out", n), {14'd0, addr0_out}, {14'd0, v.o0});
        check($sformatf("vec%0d exc_out1", n), {24'd0, exc_out1}, {24'd0, v.e1});
        if (v.chk_o1) begin
            check($sformatf("vec%0d addr1_out", n), {14'd0, addr1_out}, {14'd0, v.o1});
        end
    endtask

    task automatic write_entry(input logic [11:0] p, input logic [19:0] vpn, input logic [5:0] ppn,
                               input logic [3:0] perm, input logic g);
        read_key   = {p, vpn};
        wdata_ppn  = ppn;
        wdata_perm = perm;
        wdata_g    = g;
        we         = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [11:0] p, input logic [19:0] vpn,
                              input logic exp_hit, input logic [5:0] exp_ppn);
        read_key = {p, vpn};
        #1;
        check({name, " read_hit"}, {31'd0, read_hit}, {31'd0, exp_hit});
        check({name, " read_ppn"}, {26'd0, read_ppn}, {26'd0, exp_ppn});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int cnt;
        checks = 0;
        failures = 0;
        rst_n = 1'b1;  clk_en = 1'b1;  kmode = 1'b0;  pid = '0;
        addr0 = '0;    addr1 = '0;     acc1_wr = 1'b0; bubble1 = 1'b0;
        exc_in = '0;   read_key = '0;  we = 1'b0;      wdata_ppn = '0;
        wdata_perm = '0; wdata_g = 1'b0; flush_all = 1'b0;
        flush_pid_req = 1'b0; flush_pid = '0;
        #2;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        #1;

        // Reset state: everything misses, nothing busy
        kmode = 1'b0; pid = 12'd5; addr0 = 32'h00401000; addr1 = 32'h00401000;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset exc_out0 user", {24'd0, exc_out0}, 32'h82);
        check("reset exc_out1 user", {24'd0, exc_out1}, 32'h82);
        check_read("reset", 12'd5, 20'h00401, 1'b0, 6'h00);
        kmode = 1'b1; addr0 = 32'h00020000;
        #1;
        check("reset bypass exc_out0", {24'd0, exc_out0}, 32'h0);
        check("reset bypass addr0_out", {14'd0, addr0_out}, 32'h20000);
        kmode = 1'b0;

        // Lookup table against four known entries
        write_entry(12'd5, 20'h00401, 6'h2A, 4'b1101, 1'b0);
        write_entry(12'd5, 20'h00500, 6'h11, 4'b1011, 1'b0);
        write_entry(12'd5, 20'h00600, 6'h22, 4'b0111, 1'b0);
        write_entry(12'd9, 20'h00700, 6'h33, 4'b1111, 1'b1);

        add_vec(0, 12'd5, 32'h00401ABC, 32'h00401ABC, 0, 0, 8'h00, 8'h00, 18'h2AABC, 8'h00, 18'h2AABC, 1);
        add_vec(0, 12'd5, 32'h00401ABC, 32'h00401ABC, 1, 0, 8'h00, 8'h00, 18'h2AABC, 8'h85, 18'h00214, 1);
        add_vec(0, 12'd6, 32'h00401ABC, 32'h00401ABC, 0, 0, 8'h00, 8'h82, 18'h00000, 8'h82, 18'h00208, 1);
        add_vec(1, 12'd6, 32'h00401ABC, 32'h00401ABC, 0, 0, 8'h00, 8'h83, 18'h00000, 8'h83, 18'h0020C, 1);
        add_vec(1, 12'd5, 32'h00401ABC, 32'h00401ABC, 1, 0, 8'h00, 8'h00, 18'h2AABC, 8'h85, 18'h00214, 1);
        add_vec(0, 12'd5, 32'h00500123, 32'h00500123, 1, 0, 8'h00, 8'h86, 18'h00000, 8'h00, 18'h11123, 1);
        add_vec(0, 12'd5, 32'h00500123, 32'h00500123, 0, 0, 8'h00, 8'h86, 18'h00000, 8'h00, 18'h11123, 1);
        add_vec(0, 12'd5, 32'h00600456, 32'h00600456, 0, 0, 8'h00, 8'h84, 18'h00000, 8'h84, 18'h00210, 1);
        add_vec(1, 12'd5, 32'h00600456, 32'h00600456, 0, 0, 8'h00, 8'h00, 18'h22456, 8'h00, 18'h22456, 1);
        add_vec(0, 12'd5, 32'h00700FFF, 32'h00700FFF, 1, 0, 8'h00, 8'h00, 18'h33FFF, 8'h00, 18'h33FFF, 1);
        add_vec(0, 12'd6, 32'h00401ABC, 32'h00401ABC, 0, 0, 8'h81, 8'h82, 18'h00000, 8'h81, 18'h00204, 1);
        add_vec(0, 12'd6, 32'h00401ABC, 32'h00401ABC, 0, 1, 8'h00, 8'h82, 18'h00000, 8'h00, 18'h00000, 0);
        add_vec(0, 12'd6, 32'h00401ABC, 32'h00401ABC, 0, 1, 8'h81, 8'h82, 18'h00000, 8'h81, 18'h00204, 1);
        add_vec(1, 12'd6, 32'h0002FFFF, 32'h00012345, 1, 0, 8'h00, 8'h00, 18'h2FFFF, 8'h00, 18'h12345, 1);
        add_vec(1, 12'd6, 32'h00030000, 32'h00030000, 0, 0, 8'h00, 8'h83, 18'h00000, 8'h83, 18'h0020C, 1);
        add_vec(0, 12'd6, 32'h00012345, 32'h00012345, 0, 0, 8'h00, 8'h82, 18'h00000, 8'h82, 18'h00208, 1);

        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            checkOutput(i, vq[i]);
        end
        kmode = 1'b0; acc1_wr = 1'b0; bubble1 = 1'b0; exc_in = 8'h00;

        check_read("key5_401", 12'd5, 20'h00401, 1'b1, 6'h2A);
        check_read("key6_401", 12'd6, 20'h00401, 1'b0, 6'h00);
        check_read("global exact", 12'd5, 20'h00700, 1'b0, 6'h00);

        // Replacement: 17 keys into 16 entries, then an in-place rewrite
        do_reset();
        for (int i = 0; i < 17; i++) begin
            write_entry(12'd1, 20'(32'h10000 + i), 6'(i), 4'hF, 1'b0);
        end
        check_read("repl key0 evicted", 12'd1, 20'h10000, 1'b0, 6'h00);
        check_read("repl key16", 12'd1, 20'h10010, 1'b1, 6'd16);
        check_read("repl key1", 12'd1, 20'h10001, 1'b1, 6'd1);
        write_entry(12'd1, 20'h10002, 6'h3F, 4'hF, 1'b0);
        check_read("repl key2 rewrite", 12'd1, 20'h10002, 1'b1, 6'h3F);
        check_read("repl key3 kept", 12'd1, 20'h10003, 1'b1, 6'd3);
        write_entry(12'd1, 20'h10011, 6'd17, 4'hF, 1'b0);
        check_read("repl key1 evicted", 12'd1, 20'h10001, 1'b0, 6'h00);
        check_read("repl key2 survives", 12'd1, 20'h10002, 1'b1, 6'h3F);
        check_read("repl key17", 12'd1, 20'h10011, 1'b1, 6'd17);

        // Clock enable low: neither a write nor a flush takes effect
        clk_en = 1'b0;
        write_entry(12'd1, 20'h10020, 6'd20, 4'hF, 1'b0);
        flush_all = 1'b1;
        @(posedge clk);
        #1;
        flush_all = 1'b0;
        clk_en = 1'b1;
        check_read("clk_en write dropped", 12'd1, 20'h10020, 1'b0, 6'h00);
        check_read("clk_en flush ignored", 12'd1, 20'h10003, 1'b1, 6'd3);

        // PID sweep with a write dropped mid-sweep
        do_reset();
        write_entry(12'd5, 20'h20001, 6'h01, 4'hF, 1'b0);
        write_entry(12'd5, 20'h20002, 6'h02, 4'hF, 1'b1);
        write_entry(12'd5, 20'h20003, 6'h03, 4'hF, 1'b1);
        write_entry(12'd5, 20'h20004, 6'h04, 4'hF, 1'b0);
        write_entry(12'd7, 20'h20005, 6'h05, 4'hF, 1'b0);
        write_entry(12'd7, 20'h20006, 6'h06, 4'hF, 1'b0);
        flush_pid = 12'd5;
        flush_pid_req = 1'b1;
        @(posedge clk);
        #1;
        flush_pid_req = 1'b0;
        check("sweep busy start", {31'd0, busy}, 32'd1);
        cnt = 0;
        while (busy && cnt < 40) begin
            if (cnt == 5) begin
                read_key = {12'd7, 20'h20009};
                wdata_ppn = 6'h09; wdata_perm = 4'hF; wdata_g = 1'b0;
                we = 1'b1;
            end
            @(posedge clk);
            #1;
            we = 1'b0;
            cnt++;
        end
        check("sweep busy cycles", cnt, 32'd16);
        check_read("sweep A", 12'd5, 20'h20001, 1'b0, 6'h00);
        check_read("sweep B global", 12'd5, 20'h20002, 1'b1, 6'h02);
        check_read("sweep C global", 12'd5, 20'h20003, 1'b1, 6'h03);
        check_read("sweep D", 12'd5, 20'h20004, 1'b0, 6'h00);
        check_read("sweep E", 12'd7, 20'h20005, 1'b1, 6'h05);
        check_read("sweep F", 12'd7, 20'h20006, 1'b1, 6'h06);
        check_read("sweep dropped write", 12'd7, 20'h20009, 1'b0, 6'h00);
        kmode = 1'b0; pid = 12'd5; addr1 = 32'h20002345;
        #1;
        check("sweep global lookup", {14'd0, addr1_out}, 32'h02345);

        // Abort: flush_all together with a write on sweep cycle 4
        flush_pid = 12'd7;
        flush_pid_req = 1'b1;
        @(posedge clk);
        #1;
        flush_pid_req = 1'b0;
        cnt = 0;
        while (cnt < 3 && busy) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("abort still busy", {31'd0, busy}, 32'd1);
        flush_all = 1'b1;
        read_key = {12'd5, 20'h20010};
        wdata_ppn = 6'h10; wdata_perm = 4'hF; wdata_g = 1'b1;
        we = 1'b1;
        @(posedge clk);
        #1;
        flush_all = 1'b0;
        we = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check_read("abort write dropped", 12'd5, 20'h20010, 1'b0, 6'h00);
        check_read("abort B", 12'd5, 20'h20002, 1'b0, 6'h00);
        pid = 12'd5; addr0 = 32'h20002000; addr1 = 32'h20002000;
        #1;
        check("abort exc_out0", {24'd0, exc_out0}, 32'h82);
        check("abort exc_out1", {24'd0, exc_out1}, 32'h82);

        // Reset in the middle of a sweep
        write_entry(12'd3, 20'h30000, 6'h07, 4'hF, 1'b0);
        flush_pid = 12'd3;
        flush_pid_req = 1'b1;
        @(posedge clk);
        #1;
        flush_pid_req = 1'b0;
        check("midreset busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
